// File: rtl/fta_bus_pkg.sv
// Shared types for the WB-to-FTA bridge: tid tags, CSR offsets,
// FTA command/error codes and the bridge state encoding.
package fta_bus_pkg;

    localparam logic [3:0] TAG_NORM = 4'd1;
    localparam logic [3:0] TAG_COPY = 4'd2;

    typedef enum logic [2:0] {
        OFF_SRC    = 3'd0,
        OFF_DST    = 3'd1,
        OFF_BLEN   = 3'd2,
        OFF_DATA   = 3'd3,
        OFF_STATUS = 3'd4,
        OFF_ST_RTY = 3'd5,
        OFF_ST_TO  = 3'd6,
        OFF_ST_OPS = 3'd7
    } csr_off_e;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_RSP,
        BACKOFF,
        DONE
    } b2_state_e;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        LOAD     = 2'd1,
        STORE    = 2'd2
    } fta_cmd_e;

    typedef enum logic [1:0] {
        OKAY    = 2'd0,
        DECERR  = 2'd1,
        PROTERR = 2'd2,
        ERR     = 2'd3
    } fta_err_e;

    function automatic logic [31:0] status_word(
        input logic       to,
        input logic       re,
        input logic [9:0] cnt
    );
        return {20'd0, to, re, cnt};
    endfunction

endpackage

// File: rtl/wb_to_fta_bridge2_if.sv
// Bus interfaces used by the bridge.
// wb_bus_interface: WB request in / response out; fta_bus_interface: FTA request / response.
interface wb_bus_interface #(
    parameter int WID = 256
);
    import fta_bus_pkg::*;

    typedef struct packed {
        logic             cyc;
        logic             stb;
        logic             we;
        logic [7:0]       blen;
        logic [WID/8-1:0] sel;
        logic [31:0]      adr;
        logic [WID-1:0]   dat;
    } req_t;

    typedef struct packed {
        logic           ack;
        fta_err_e       err;
        logic [WID-1:0] dat;
    } resp_t;

    req_t  req;
    resp_t resp;

    modport master (output req, input resp);
    modport slave  (input req, output resp);
endinterface

interface fta_bus_interface #(
    parameter int WID = 256
);
    import fta_bus_pkg::*;

    typedef struct packed {
        logic             cyc;
        logic             we;
        fta_cmd_e         cmd;
        logic [12:0]      tid;
        logic [7:0]       blen;
        logic [WID/8-1:0] sel;
        logic [31:0]      adr;
        logic [WID-1:0]   data1;
    } req_t;

    typedef struct packed {
        logic           ack;
        logic           rty;
        logic           stall;
        fta_err_e       err;
        logic [12:0]    tid;
        logic [WID-1:0] dat;
    } resp_t;

    req_t  req;
    resp_t resp;

    modport master (output req, input resp);
    modport slave  (input req, output resp);
endinterface

// File: rtl/wb2fta_rty_ctrl.sv
// Retry / backoff / timeout bookkeeping for the bridge.
// Ports: i_clr (idle), i_issue, i_wait, i_rty, i_backoff in; o_reissue, o_exhaust, o_timeout, o_rty_cnt out.
module wb2fta_rty_ctrl #(
    parameter int RETRIES = 300,
    parameter int RTY_DLY = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clr,
    input  logic       i_issue,
    input  logic       i_wait,
    input  logic       i_rty,
    input  logic       i_backoff,
    output logic       o_reissue,
    output logic       o_exhaust,
    output logic       o_timeout,
    output logic [9:0] o_rty_cnt
);
    localparam logic [3:0]  BO_LAST = (RTY_DLY > 0) ? 4'(RTY_DLY - 1) : 4'd0;
    localparam logic [9:0]  RTY_LIM = 10'(RETRIES);
    localparam logic [10:0] TO_LIM  = 11'(TIMEOUT);

    logic [9:0] r_rty;
    logic [3:0] r_bo;
    logic [9:0] r_wait;

    // Exhaustion is judged on the count of reissues already made.
    assign o_exhaust = i_rty && (r_rty == RTY_LIM);
    assign o_reissue = i_backoff && (r_bo == BO_LAST);
    assign o_timeout = (TIMEOUT != 0) && i_wait
                       && (({1'b0, r_wait} + 11'd1) == TO_LIM);
    assign o_rty_cnt = r_rty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rty  <= '0;
            r_bo   <= '0;
            r_wait <= '0;
        end else begin
            if (i_clr)
                r_rty <= '0;
            else if (i_rty && !o_exhaust)
                r_rty <= r_rty + 10'd1;

            if (i_backoff)
                r_bo <= r_bo + 4'd1;
            else
                r_bo <= '0;

            if (i_issue || i_clr)
                r_wait <= '0;
            else if (i_wait)
                r_wait <= r_wait + 10'd1;
        end
    end

endmodule

// File: rtl/wb_to_fta_bridge2.sv
// WB slave to FTA master bridge with retry/backoff, timeout and a CSR copy window.
// Ports: clk_i, rst_i, cs_i, wb_i (slave), fta_o (master). Option: WB2FTA_STATS_EN adds counters.
module wb_to_fta_bridge2
    import fta_bus_pkg::*;
#(
    parameter int          WID       = 256,
    parameter logic [5:0]  CORENO    = 6'd1,
    parameter logic [2:0]  CHANNEL   = 3'd0,
    parameter int          RETRIES   = 300,
    parameter int          RTY_DLY   = 4,
    parameter int          TIMEOUT   = 1023,
    parameter bit          POSTED_WR = 1'b0,
    parameter logic [31:0] CSR_ADR   = 32'hBFFFFFE0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cs_i,
    wb_bus_interface.slave   wb_i,
    fta_bus_interface.master fta_o
);
    b2_state_e r_state, w_next;

    logic             r_we;
    logic [3:0]       r_tag;
    logic [WID/8-1:0] r_sel;
    logic [31:0]      r_adr;
    logic [7:0]       r_blen;
    logic [WID-1:0]   r_data;
    logic [31:0]      r_src, r_dst;
    logic [7:0]       r_blen_csr;
    logic             r_to, r_re;
    logic [9:0]       r_rcl;
    logic             r_ack;
    fta_err_e         r_err;
    logic [WID-1:0]   r_dat;

    logic           w_valid, w_hit, w_csr, w_match, w_rack, w_rrty;
    logic           w_issue, w_wait, w_rty_in, w_bo;
    logic           w_reissue, w_exh, w_to;
    logic [9:0]     w_rcnt;
    csr_off_e       w_off;
    logic [31:0]    w_csr_rd;
    logic           w_load, w_fin, w_set_to, w_set_re, w_csr_wr;
    fta_err_e       w_fin_err;
    logic [WID-1:0] w_fin_dat;

    assign w_valid = wb_i.req.cyc && wb_i.req.stb && cs_i;
    assign w_hit   = (wb_i.req.adr[31:5] == CSR_ADR[31:5]);
    assign w_off   = csr_off_e'(wb_i.req.adr[4:2]);
    assign w_csr   = w_hit && (w_off != OFF_DATA);
    assign w_match = (fta_o.resp.tid == {CORENO, CHANNEL, r_tag});
    assign w_rack  = fta_o.resp.ack && w_match;
    assign w_rrty  = fta_o.resp.rty && w_match && !fta_o.resp.ack;

    assign w_issue  = (r_state == ISSUE);
    assign w_wait   = (r_state == WAIT_RSP) && w_valid && !w_rack && !w_rrty;
    assign w_rty_in = (r_state == WAIT_RSP) && w_valid && w_rrty;
    assign w_bo     = (r_state == BACKOFF) && w_valid;

    wb2fta_rty_ctrl #(
        .RETRIES (RETRIES),
        .RTY_DLY (RTY_DLY),
        .TIMEOUT (TIMEOUT)
    ) u_rty (
        .i_clk     (clk_i),
        .i_rst     (rst_i),
        .i_clr     (r_state == IDLE),
        .i_issue   (w_issue),
        .i_wait    (w_wait),
        .i_rty     (w_rty_in),
        .i_backoff (w_bo),
        .o_reissue (w_reissue),
        .o_exhaust (w_exh),
        .o_timeout (w_to),
        .o_rty_cnt (w_rcnt)
    );

    // Request is only driven during ISSUE; all-zero otherwise.
    assign fta_o.req.cyc   = w_issue;
    assign fta_o.req.we    = w_issue && r_we;
    assign fta_o.req.cmd   = w_issue ? (r_we ? STORE : LOAD) : CMD_NONE;
    assign fta_o.req.tid   = w_issue ? {CORENO, CHANNEL, r_tag} : '0;
    assign fta_o.req.blen  = w_issue ? r_blen : '0;
    assign fta_o.req.sel   = w_issue ? r_sel : '0;
    assign fta_o.req.adr   = w_issue ? r_adr : '0;
    assign fta_o.req.data1 = w_issue ? r_data : '0;

    assign wb_i.resp.ack = r_ack;
    assign wb_i.resp.err = r_err;
    assign wb_i.resp.dat = r_dat;

`ifdef WB2FTA_STATS_EN
    logic [31:0] r_st_rty, r_st_to, r_st_ops;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_st_rty <= '0;
            r_st_to  <= '0;
            r_st_ops <= '0;
        end else if (w_csr_wr && (w_off >= OFF_ST_RTY)) begin
            r_st_rty <= '0;
            r_st_to  <= '0;
            r_st_ops <= '0;
        end else begin
            if (w_rty_in && !(&r_st_rty)) r_st_rty <= r_st_rty + 32'd1;
            if (w_set_to && !(&r_st_to))  r_st_to  <= r_st_to + 32'd1;
            if (w_fin && !(&r_st_ops))    r_st_ops <= r_st_ops + 32'd1;
        end
    end
`endif

    always_comb begin
        w_csr_rd = '0;
        case (w_off)
            OFF_SRC:    w_csr_rd = r_src;
            OFF_DST:    w_csr_rd = r_dst;
            OFF_BLEN:   w_csr_rd = {24'd0, r_blen_csr};
            OFF_STATUS: w_csr_rd = status_word(r_to, r_re, r_rcl);
`ifdef WB2FTA_STATS_EN
            OFF_ST_RTY: w_csr_rd = r_st_rty;
            OFF_ST_TO:  w_csr_rd = r_st_to;
            OFF_ST_OPS: w_csr_rd = r_st_ops;
`endif
            default:    w_csr_rd = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_fin     = 1'b0;
        w_fin_err = OKAY;
        w_fin_dat = '0;
        w_set_to  = 1'b0;
        w_set_re  = 1'b0;
        w_csr_wr  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_valid) begin
                    if (w_csr) begin
                        w_csr_wr  = wb_i.req.we;
                        w_fin     = 1'b1;
                        w_fin_dat = wb_i.req.we ? '0 : {(WID/32){w_csr_rd}};
                        w_next    = DONE;
                    end else if (!fta_o.resp.stall) begin
                        w_load = 1'b1;
                        w_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (POSTED_WR && r_we) begin
                    w_fin  = 1'b1;
                    w_next = DONE;
                end else begin
                    w_next = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (!w_valid) begin
                    w_next = IDLE;
                end else if (w_rack) begin
                    w_fin     = 1'b1;
                    w_fin_dat = fta_o.resp.dat;
                    w_fin_err = (fta_o.resp.err != OKAY) ? ERR : OKAY;
                    w_next    = DONE;
                end else if (w_rrty) begin
                    if (w_exh) begin
                        w_fin     = 1'b1;
                        w_fin_err = ERR;
                        w_set_re  = 1'b1;
                        w_next    = DONE;
                    end else begin
                        w_next = (RTY_DLY == 0) ? ISSUE : BACKOFF;
                    end
                end else if (w_to) begin
                    w_fin     = 1'b1;
                    w_fin_err = ERR;
                    w_set_to  = 1'b1;
                    w_next    = DONE;
                end
            end
            BACKOFF: begin
                if (!w_valid)      w_next = IDLE;
                else if (w_reissue) w_next = ISSUE;
            end
            DONE: begin
                if (!w_valid) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_we       <= 1'b0;
            r_tag      <= '0;
            r_sel      <= '0;
            r_adr      <= '0;
            r_blen     <= '0;
            r_data     <= '0;
            r_src      <= '0;
            r_dst      <= '0;
            r_blen_csr <= '0;
            r_to       <= 1'b0;
            r_re       <= 1'b0;
            r_rcl      <= '0;
            r_ack      <= 1'b0;
            r_err      <= OKAY;
            r_dat      <= '0;
        end else begin
            // Request fields are frozen here so reissues repeat them exactly.
            if (w_load) begin
                r_we   <= wb_i.req.we;
                r_data <= wb_i.req.dat;
                if (w_hit) begin
                    r_tag  <= TAG_COPY;
                    r_sel  <= '1;
                    r_adr  <= wb_i.req.we ? r_dst : r_src;
                    r_blen <= r_blen_csr;
                end else begin
                    r_tag  <= TAG_NORM;
                    r_sel  <= wb_i.req.sel;
                    r_adr  <= wb_i.req.adr;
                    r_blen <= wb_i.req.blen;
                end
            end

            if (w_fin) begin
                r_ack <= 1'b1;
                r_err <= w_fin_err;
                r_dat <= w_fin_dat;
                r_rcl <= w_rcnt;
            end else if ((r_state == DONE) && !w_valid) begin
                r_ack <= 1'b0;
                r_err <= OKAY;
                r_dat <= '0;
            end

            if (w_csr_wr) begin
                case (w_off)
                    OFF_SRC:    r_src      <= wb_i.req.dat[31:0];
                    OFF_DST:    r_dst      <= wb_i.req.dat[31:0];
                    OFF_BLEN:   r_blen_csr <= wb_i.req.dat[7:0];
                    OFF_STATUS: begin
                        r_to <= 1'b0;
                        r_re <= 1'b0;
                    end
                    default: ;
                endcase
            end
            if (w_set_to) r_to <= 1'b1;
            if (w_set_re) r_re <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_to_fta_bridge2.sv
// Directed bench for wb_to_fta_bridge2 (WID=64, RETRIES=3, RTY_DLY=4,
// TIMEOUT=16, POSTED_WR=1).
module tb_wb_to_fta_bridge2;
    import fta_bus_pkg::*;

    localparam int          W    = 64;
    localparam logic [31:0] CSR  = 32'hBFFFFFE0;
    localparam logic [12:0] TIDN = 13'h081;
    localparam logic [12:0] TIDC = 13'h082;
    localparam logic [12:0] TIDX = 13'h085;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cs  = 1'b0;
    int n_chk = 0;
    int n_pass = 0;
    int cyc_n = 0;
    int n_req = 0;
    int req_cyc = 0;

    wb_bus_interface  #(.WID(W)) wb ();
    fta_bus_interface #(.WID(W)) fta ();

    wb_to_fta_bridge2 #(
        .WID       (W),
        .CORENO    (6'd1),
        .CHANNEL   (3'd0),
        .RETRIES   (3),
        .RTY_DLY   (4),
        .TIMEOUT   (16),
        .POSTED_WR (1'b1),
        .CSR_ADR   (CSR)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .cs_i  (cs),
        .wb_i  (wb.slave),
        .fta_o (fta.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n++;
    always @(negedge clk) if (fta.req.cyc) n_req++;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_go(input logic [31:0] adr, input bit we,
                         input logic [W-1:0] dat);
        wb.req.cyc  = 1'b1;
        wb.req.stb  = 1'b1;
        wb.req.we   = we;
        wb.req.adr  = adr;
        wb.req.dat  = dat;
        wb.req.sel  = '1;
        wb.req.blen = '0;
        cs = 1'b1;
    endtask

    task automatic wb_drop();
        wb.req.cyc = 1'b0;
        wb.req.stb = 1'b0;
    endtask

    task automatic wait_req(output bit got);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (fta.req.cyc) begin
                got = 1'b1;
                req_cyc = cyc_n;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_ack(output bit got);
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (wb.resp.ack) begin
                got = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic pulse_rsp(input bit a, input bit r, input logic [12:0] tid,
                             input logic [W-1:0] d, input fta_err_e e);
        fta.resp.ack = a;
        fta.resp.rty = r;
        fta.resp.tid = tid;
        fta.resp.dat = d;
        fta.resp.err = e;
        tick();
        fta.resp = '0;
    endtask

    task automatic csr_op(input logic [2:0] off, input bit we,
                          input logic [31:0] wd,
                          output logic [W-1:0] rd, output bit got);
        wb_go(CSR + {27'd0, off, 2'b00}, we, {2{wd}});
        wait_ack(got);
        rd = wb.resp.dat;
        wb_drop();
        tick();
    endtask

    task automatic test_reset();
        logic [W-1:0] d;
        bit got;
        #1;
        n_chk++;
        if (fta.req.cyc !== 1'b0 || fta.req.tid !== 13'd0 || fta.req.adr !== 32'd0)
            $display("FAIL reset_req: cyc %b tid %h adr %h want 0", fta.req.cyc, fta.req.tid, fta.req.adr);
        else n_pass++;
        n_chk++;
        if (wb.resp.ack !== 1'b0 || wb.resp.err !== OKAY || wb.resp.dat !== '0)
            $display("FAIL reset_resp: ack %b err %0d dat %h want 0/0/0", wb.resp.ack, wb.resp.err, wb.resp.dat);
        else n_pass++;
        tick();
        rst = 1'b0;
        tick();
        csr_op(3'd4, 1'b0, 32'd0, d, got);
        n_chk++;
        if (!got || d !== 64'd0)
            $display("FAIL reset_status: got %b dat %h want 1/0", got, d);
        else n_pass++;
    endtask

    task automatic test_read();
        bit got;
        int n0;
        n0 = n_req;
        wb_go(32'h0000_1000, 1'b0, '0);
        wait_req(got);
        n_chk++;
        if (!got || fta.req.adr !== 32'h1000 || fta.req.cmd !== LOAD
            || fta.req.tid !== TIDN || fta.req.sel !== 8'hFF)
            $display("FAIL read_req: got %b adr %h cmd %0d tid %h sel %h want 1/1000/1/081/ff",
                     got, fta.req.adr, fta.req.cmd, fta.req.tid, fta.req.sel);
        else n_pass++;
        tick(); tick(); tick();
        n_chk++;
        if (wb.resp.ack !== 1'b0)
            $display("FAIL read_early_ack: ack %b want 0", wb.resp.ack);
        else n_pass++;
        pulse_rsp(1'b1, 1'b0, TIDN, 64'hA5A5_A5A5_A5A5_A5A5, OKAY);
        n_chk++;
        if (wb.resp.ack !== 1'b1 || wb.resp.dat !== 64'hA5A5_A5A5_A5A5_A5A5 || wb.resp.err !== OKAY)
            $display("FAIL read_ack: ack %b dat %h err %0d want 1/a5../0", wb.resp.ack, wb.resp.dat, wb.resp.err);
        else n_pass++;
        n_chk++;
        if (n_req - n0 !== 1)
            $display("FAIL read_pulses: %0d want 1", n_req - n0);
        else n_pass++;
        wb_drop();
        tick();
        n_chk++;
        if (wb.resp.ack !== 1'b0 || wb.resp.dat !== '0)
            $display("FAIL read_release: ack %b dat %h want 0/0", wb.resp.ack, wb.resp.dat);
        else n_pass++;
    endtask

    task automatic test_retry();
        bit got;
        int n0, c1, c2, c3;
        logic [W-1:0] d;
        n0 = n_req;
        wb_go(32'h0000_1040, 1'b0, '0);
        wait_req(got);
        c1 = req_cyc;
        tick();
        pulse_rsp(1'b0, 1'b1, TIDN, '0, OKAY);
        wait_req(got);
        c2 = req_cyc;
        n_chk++;
        if (!got || c2 - c1 < 5)
            $display("FAIL retry_gap1: got %b gap %0d want >=5", got, c2 - c1);
        else n_pass++;
        n_chk++;
        if (fta.req.adr !== 32'h1040 || fta.req.tid !== TIDN)
            $display("FAIL retry_fields: adr %h tid %h want 1040/081", fta.req.adr, fta.req.tid);
        else n_pass++;
        tick();
        pulse_rsp(1'b0, 1'b1, TIDN, '0, OKAY);
        wait_req(got);
        c3 = req_cyc;
        n_chk++;
        if (!got || c3 - c2 < 5)
            $display("FAIL retry_gap2: got %b gap %0d want >=5", got, c3 - c2);
        else n_pass++;
        tick();
        pulse_rsp(1'b1, 1'b0, TIDN, 64'h0000_0000_1111_2222, OKAY);
        n_chk++;
        if (wb.resp.ack !== 1'b1 || wb.resp.err !== OKAY || n_req - n0 !== 3)
            $display("FAIL retry_done: ack %b err %0d pulses %0d want 1/0/3",
                     wb.resp.ack, wb.resp.err, n_req - n0);
        else n_pass++;
        wb_drop();
        tick();
        csr_op(3'd4, 1'b0, 32'd0, d, got);
        n_chk++;
        if (!got || d !== 64'h0000_0002_0000_0002)
            $display("FAIL retry_status: got %b dat %h want 0000000200000002", got, d);
        else n_pass++;
    endtask

    task automatic test_exhaust();
        bit got, all;
        int n0;
        logic [W-1:0] d;
        n0 = n_req;
        all = 1'b1;
        wb_go(32'h0000_1080, 1'b0, '0);
        for (int r = 0; r < 4; r++) begin
            wait_req(got);
            all &= got;
            tick();
            pulse_rsp(1'b0, 1'b1, TIDN, '0, OKAY);
        end
        n_chk++;
        if (!all || wb.resp.ack !== 1'b1 || wb.resp.err !== ERR)
            $display("FAIL exhaust_err: reqs %b ack %b err %0d want 1/1/3", all, wb.resp.ack, wb.resp.err);
        else n_pass++;
        wb_drop();
        tick(); tick(); tick();
        n_chk++;
        if (n_req - n0 !== 4)
            $display("FAIL exhaust_pulses: %0d want 4", n_req - n0);
        else n_pass++;
        csr_op(3'd4, 1'b0, 32'd0, d, got);
        n_chk++;
        if (!got || d[10] !== 1'b1 || d[11] !== 1'b0)
            $display("FAIL exhaust_re: got %b status %h want RE=1 TO=0", got, d[31:0]);
        else n_pass++;
        csr_op(3'd4, 1'b1, 32'd0, d, got);
        csr_op(3'd4, 1'b0, 32'd0, d, got);
        n_chk++;
        if (!got || d[11:10] !== 2'b00)
            $display("FAIL exhaust_clear: got %b status %h want RE=0", got, d[31:0]);
        else n_pass++;
    endtask

    task automatic test_timeout();
        bit got;
        int t;
        logic [W-1:0] d;
        wb_go(32'h0000_10C0, 1'b0, '0);
        wait_req(got);
        t = 0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 4) fta.resp = '0;
            tick();
            if (i == 3) begin
                fta.resp.ack = 1'b1;
                fta.resp.tid = TIDX;
                fta.resp.dat = 64'hFFFF;
            end
            if (wb.resp.ack) begin
                t = i;
                break;
            end
        end
        fta.resp = '0;
        n_chk++;
        if (t !== 17 || wb.resp.err !== ERR)
            $display("FAIL timeout_ack: after %0d cycles err %0d want 17/3", t, wb.resp.err);
        else n_pass++;
        wb_drop();
        tick();
        csr_op(3'd4, 1'b0, 32'd0, d, got);
        n_chk++;
        if (!got || d[11] !== 1'b1)
            $display("FAIL timeout_status: got %b status %h want TO=1", got, d[31:0]);
        else n_pass++;
        csr_op(3'd4, 1'b1, 32'd0, d, got);
    endtask

    task automatic test_csr_copy();
        bit got;
        logic [W-1:0] d;
        csr_op(3'd0, 1'b1, 32'h0000_2000, d, got);
        csr_op(3'd2, 1'b1, 32'h0000_0003, d, got);
        csr_op(3'd0, 1'b0, 32'd0, d, got);
        n_chk++;
        if (!got || d !== 64'h0000_2000_0000_2000)
            $display("FAIL csr_src_rd: got %b dat %h want 0000200000002000", got, d);
        else n_pass++;
        csr_op(3'd6, 1'b0, 32'd0, d, got);
        n_chk++;
        if (!got || d !== 64'd0)
            $display("FAIL csr_unused_rd: got %b dat %h want 0", got, d);
        else n_pass++;
        wb_go(CSR + 32'h0C, 1'b0, '0);
        wait_req(got);
        n_chk++;
        if (!got || fta.req.adr !== 32'h2000 || fta.req.blen !== 8'd3
            || fta.req.sel !== 8'hFF || fta.req.tid !== TIDC)
            $display("FAIL copy_req: got %b adr %h blen %0d sel %h tid %h want 1/2000/3/ff/082",
                     got, fta.req.adr, fta.req.blen, fta.req.sel, fta.req.tid);
        else n_pass++;
        tick();
        pulse_rsp(1'b1, 1'b0, TIDN, 64'h77, OKAY);
        n_chk++;
        if (wb.resp.ack !== 1'b0)
            $display("FAIL copy_tid_filter: ack %b want 0", wb.resp.ack);
        else n_pass++;
        pulse_rsp(1'b1, 1'b0, TIDC, 64'h1234_5678_9ABC_DEF0, DECERR);
        n_chk++;
        if (wb.resp.ack !== 1'b1 || wb.resp.dat !== 64'h1234_5678_9ABC_DEF0 || wb.resp.err !== ERR)
            $display("FAIL copy_ack: ack %b dat %h err %0d want 1/123456789abcdef0/3",
                     wb.resp.ack, wb.resp.dat, wb.resp.err);
        else n_pass++;
        wb_drop();
        tick();
    endtask

    task automatic test_posted();
        bit got;
        wb_go(32'h0000_1100, 1'b1, 64'hDEAD_BEEF_0123_4567);
        wait_req(got);
        n_chk++;
        if (!got || fta.req.cmd !== STORE || fta.req.data1 !== 64'hDEAD_BEEF_0123_4567)
            $display("FAIL posted_req: got %b cmd %0d data %h want 1/2/deadbeef01234567",
                     got, fta.req.cmd, fta.req.data1);
        else n_pass++;
        tick();
        n_chk++;
        if (wb.resp.ack !== 1'b1 || wb.resp.err !== OKAY)
            $display("FAIL posted_ack: ack %b err %0d want 1/0", wb.resp.ack, wb.resp.err);
        else n_pass++;
        wb_drop();
        tick();
    endtask

    task automatic test_abort();
        bit got;
        int n0;
        n0 = n_req;
        wb_go(32'h0000_1140, 1'b0, '0);
        wait_req(got);
        tick(); tick();
        wb_drop();
        tick();
        pulse_rsp(1'b1, 1'b0, TIDN, 64'h55, OKAY);
        tick();
        n_chk++;
        if (wb.resp.ack !== 1'b0 || n_req - n0 !== 1)
            $display("FAIL abort: ack %b pulses %0d want 0/1", wb.resp.ack, n_req - n0);
        else n_pass++;
        wb_go(32'h0000_1180, 1'b0, '0);
        wait_req(got);
        tick();
        pulse_rsp(1'b1, 1'b0, TIDN, 64'h0BAD_F00D, OKAY);
        n_chk++;
        if (!got || wb.resp.ack !== 1'b1 || wb.resp.dat !== 64'h0BAD_F00D)
            $display("FAIL abort_recover: got %b ack %b dat %h want 1/1/0badf00d",
                     got, wb.resp.ack, wb.resp.dat);
        else n_pass++;
        wb_drop();
        tick();
    endtask

    task automatic test_reset_mid();
        bit got;
        logic [W-1:0] d;
        wb_go(32'h0000_11C0, 1'b0, '0);
        wait_req(got);
        rst = 1'b1;
        #1;
        n_chk++;
        if (!got || fta.req.cyc !== 1'b0 || wb.resp.ack !== 1'b0)
            $display("FAIL reset_mid: got %b cyc %b ack %b want 1/0/0", got, fta.req.cyc, wb.resp.ack);
        else n_pass++;
        wb_drop();
        tick();
        rst = 1'b0;
        tick();
        csr_op(3'd0, 1'b0, 32'd0, d, got);
        n_chk++;
        if (!got || d !== 64'd0)
            $display("FAIL reset_mid_src: got %b dat %h want 0", got, d);
        else n_pass++;
    endtask

    initial begin
        wb.req   = '0;
        fta.resp = '0;
        test_reset();
        test_read();
        test_retry();
        test_exhaust();
        test_timeout();
        test_csr_copy();
        test_posted();
        test_abort();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
